// File: rtl/tick_gen_multi_if.sv
// Control/status bundle for tick_gen_multi: per-channel enable/mode/restart,
// period write port, and the registered tick/busy/done outputs.
interface tick_gen_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] mode;
  logic [NUM_CH-1:0] restart;
  logic              period_we;
  logic [CH_W-1:0]   period_ch;
  logic [CNT_W-1:0]  period_wdata;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] done;

  modport master (
    output en, mode, restart, period_we, period_ch, period_wdata,
    input  tick, busy, done
  );

  modport slave (
    input  en, mode, restart, period_we, period_ch, period_wdata,
    output tick, busy, done
  );
endinterface

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator: per-channel IDLE/RUN/DONE FSM with
// periodic or one-shot mode, restart, and period updates applied at wrap/restart.
module tick_gen_multi #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 10_000_000
) (
  input logic             clk,
  input logic             reset,
  tick_gen_multi_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state   [NUM_CH];
  state_t            w_state_n [NUM_CH];
  logic [CNT_W-1:0]  r_cnt     [NUM_CH];
  logic [CNT_W-1:0]  w_cnt_n   [NUM_CH];
  logic [CNT_W-1:0]  r_act     [NUM_CH];
  logic [CNT_W-1:0]  w_act_n   [NUM_CH];
  logic [CNT_W-1:0]  r_pend    [NUM_CH];
  logic [CNT_W-1:0]  w_pend_n  [NUM_CH];
  logic [NUM_CH-1:0] r_mode;
  logic [NUM_CH-1:0] w_mode_n;
  logic [NUM_CH-1:0] w_tick_n;
  logic [NUM_CH-1:0] r_tick;
  logic [NUM_CH-1:0] r_busy;
  logic [NUM_CH-1:0] r_done;

  // Next-state, counter and period selection for every channel.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      // A write landing this cycle is visible to any same-cycle load (write-through).
      if (bus.period_we && (bus.period_ch == CH_W'(ch))) begin
        w_pend_n[ch] = bus.period_wdata;
      end else begin
        w_pend_n[ch] = r_pend[ch];
      end
      w_state_n[ch] = r_state[ch];
      w_cnt_n[ch]   = r_cnt[ch];
      w_act_n[ch]   = r_act[ch];
      w_mode_n[ch]  = r_mode[ch];
      w_tick_n[ch]  = 1'b0;

      case (r_state[ch])
        S_IDLE: begin
          w_cnt_n[ch] = {CNT_W{1'b0}};
          w_act_n[ch] = w_pend_n[ch];
          if (bus.en[ch]) begin
            w_state_n[ch] = S_RUN;
            w_mode_n[ch]  = bus.mode[ch];
          end else begin
            w_state_n[ch] = S_IDLE;
          end
        end
        S_RUN: begin
          if (!bus.en[ch]) begin
            w_state_n[ch] = S_IDLE;
            w_cnt_n[ch]   = {CNT_W{1'b0}};
          end else if (bus.restart[ch]) begin
            w_cnt_n[ch]  = {CNT_W{1'b0}};
            w_act_n[ch]  = w_pend_n[ch];
            w_mode_n[ch] = bus.mode[ch];
          end else if (r_act[ch] == {CNT_W{1'b0}}) begin
            w_cnt_n[ch] = {CNT_W{1'b0}};
          end else if (r_cnt[ch] == (r_act[ch] - CNT_W'(1))) begin
            w_cnt_n[ch]  = {CNT_W{1'b0}};
            w_tick_n[ch] = 1'b1;
            w_act_n[ch]  = w_pend_n[ch];
            if (r_mode[ch]) begin
              w_state_n[ch] = S_DONE;
            end else begin
              w_state_n[ch] = S_RUN;
            end
          end else begin
            w_cnt_n[ch] = r_cnt[ch] + CNT_W'(1);
          end
        end
        S_DONE: begin
          w_cnt_n[ch] = {CNT_W{1'b0}};
          if (!bus.en[ch]) begin
            w_state_n[ch] = S_IDLE;
          end else if (bus.restart[ch]) begin
            w_state_n[ch] = S_RUN;
            w_act_n[ch]   = w_pend_n[ch];
            w_mode_n[ch]  = bus.mode[ch];
          end else begin
            w_state_n[ch] = S_DONE;
          end
        end
        default: begin
          w_state_n[ch] = S_IDLE;
          w_cnt_n[ch]   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State, counters, periods and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_state[ch] <= S_IDLE;
        r_cnt[ch]   <= {CNT_W{1'b0}};
        r_act[ch]   <= DEF_P;
        r_pend[ch]  <= DEF_P;
      end
      r_mode <= {NUM_CH{1'b0}};
      r_tick <= {NUM_CH{1'b0}};
      r_busy <= {NUM_CH{1'b0}};
      r_done <= {NUM_CH{1'b0}};
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_state[ch] <= w_state_n[ch];
        r_cnt[ch]   <= w_cnt_n[ch];
        r_act[ch]   <= w_act_n[ch];
        r_pend[ch]  <= w_pend_n[ch];
        r_busy[ch]  <= (w_state_n[ch] == S_RUN);
        r_done[ch]  <= (w_state_n[ch] == S_DONE);
      end
      r_mode <= w_mode_n;
      r_tick <= w_tick_n;
    end
  end

  assign bus.tick = r_tick;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
endmodule

// File: tb/tb_tick_gen_multi.sv
// Scenario bench for tick_gen_multi (2 channels, 8-bit counters, default period 5):
// expected tick cycles are queued per channel and retired by a negedge monitor.
module tb_tick_gen_multi;
  localparam int NCH = 2;
  localparam int CW  = 8;
  localparam int DP  = 5;

  logic clk = 1'b0;
  logic reset;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   q0[$];
  int   q1[$];
  int   e0;
  int   e1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tick_gen_multi_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

  tick_gen_multi #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_PERIOD(DP)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // Retire queued tick expectations; flag unexpected, early and missing ticks.
  always @(negedge clk) begin
    if (bus.tick[0]) begin
      n_cmp++;
      if (q0.size() == 0) begin
        n_err++;
        $display("FAIL tick0_unexpected: tick at cycle %0d, expected none", cyc);
      end else begin
        e0 = q0.pop_front();
        if (e0 !== cyc) begin
          n_err++;
          $display("FAIL tick0_time: tick at cycle %0d, expected cycle %0d", cyc, e0);
        end
      end
    end else if (q0.size() > 0 && q0[0] < cyc) begin
      n_cmp++;
      n_err++;
      e0 = q0.pop_front();
      $display("FAIL tick0_missing: no tick by cycle %0d, expected cycle %0d", cyc, e0);
    end
    if (bus.tick[1]) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_err++;
        $display("FAIL tick1_unexpected: tick at cycle %0d, expected none", cyc);
      end else begin
        e1 = q1.pop_front();
        if (e1 !== cyc) begin
          n_err++;
          $display("FAIL tick1_time: tick at cycle %0d, expected cycle %0d", cyc, e1);
        end
      end
    end else if (q1.size() > 0 && q1[0] < cyc) begin
      n_cmp++;
      n_err++;
      e1 = q1.pop_front();
      $display("FAIL tick1_missing: no tick by cycle %0d, expected cycle %0d", cyc, e1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic test_reset;
    reset            = 1'b1;
    bus.en           = '0;
    bus.mode         = '0;
    bus.restart      = '0;
    bus.period_we    = 1'b0;
    bus.period_ch    = 1'b0;
    bus.period_wdata = 8'd0;
    step(3);
    n_cmp++;
    if (bus.tick !== 2'b00) begin n_err++; $display("FAIL reset_tick: got %b expected 00", bus.tick); end
    n_cmp++;
    if (bus.busy !== 2'b00) begin n_err++; $display("FAIL reset_busy: got %b expected 00", bus.busy); end
    n_cmp++;
    if (bus.done !== 2'b00) begin n_err++; $display("FAIL reset_done: got %b expected 00", bus.done); end
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_periodic;
    int c;
    c = cyc;
    bus.en[0] = 1'b1;
    q0.push_back(c + 6);
    q0.push_back(c + 11);
    q0.push_back(c + 16);
    step(1);
    n_cmp++;
    if (bus.busy[0] !== 1'b1) begin n_err++; $display("FAIL periodic_busy0: got %b expected 1", bus.busy[0]); end
    n_cmp++;
    if (bus.busy[1] !== 1'b0) begin n_err++; $display("FAIL periodic_busy1: got %b expected 0", bus.busy[1]); end
    wait_cyc(c + 17);
    bus.en[0] = 1'b0;
    step(1);
    n_cmp++;
    if (bus.busy[0] !== 1'b0) begin n_err++; $display("FAIL periodic_idle: busy got %b expected 0", bus.busy[0]); end
    n_cmp++;
    if (q0.size() !== 0) begin n_err++; $display("FAIL periodic_drain: %0d ticks outstanding, expected 0", q0.size()); end
  endtask

  task automatic test_period_update;
    int c;
    c = cyc;
    bus.en[0] = 1'b1;
    q0.push_back(c + 6);
    q0.push_back(c + 11);
    q0.push_back(c + 14);
    q0.push_back(c + 17);
    wait_cyc(c + 8);
    bus.period_we    = 1'b1;
    bus.period_ch    = 1'b0;
    bus.period_wdata = 8'd3;
    step(1);
    bus.period_we = 1'b0;
    wait_cyc(c + 18);
    bus.en[0]        = 1'b0;
    bus.period_we    = 1'b1;
    bus.period_wdata = 8'd5;
    step(1);
    bus.period_we = 1'b0;
    n_cmp++;
    if (q0.size() !== 0) begin n_err++; $display("FAIL update_drain: %0d ticks outstanding, expected 0", q0.size()); end
  endtask

  task automatic test_oneshot;
    int c;
    c = cyc;
    bus.mode[1] = 1'b1;
    bus.en[1]   = 1'b1;
    q1.push_back(c + 6);
    wait_cyc(c + 6);
    n_cmp++;
    if (bus.done[1] !== 1'b1) begin n_err++; $display("FAIL oneshot_done: got %b expected 1", bus.done[1]); end
    n_cmp++;
    if (bus.busy[1] !== 1'b0) begin n_err++; $display("FAIL oneshot_busy: got %b expected 0", bus.busy[1]); end
    wait_cyc(c + 9);
    n_cmp++;
    if (bus.done[1] !== 1'b1) begin n_err++; $display("FAIL oneshot_hold: done got %b expected 1", bus.done[1]); end
    bus.restart[1] = 1'b1;
    q1.push_back(c + 15);
    step(1);
    bus.restart[1] = 1'b0;
    n_cmp++;
    if (bus.done[1] !== 1'b0) begin n_err++; $display("FAIL oneshot_rst_done: got %b expected 0", bus.done[1]); end
    n_cmp++;
    if (bus.busy[1] !== 1'b1) begin n_err++; $display("FAIL oneshot_rst_busy: got %b expected 1", bus.busy[1]); end
    wait_cyc(c + 15);
    n_cmp++;
    if (bus.done[1] !== 1'b1) begin n_err++; $display("FAIL oneshot_done2: got %b expected 1", bus.done[1]); end
    wait_cyc(c + 22);
    bus.en[1]   = 1'b0;
    bus.mode[1] = 1'b0;
    step(1);
    n_cmp++;
    if (bus.done[1] !== 1'b0) begin n_err++; $display("FAIL oneshot_off: done got %b expected 0", bus.done[1]); end
    n_cmp++;
    if (q1.size() !== 0) begin n_err++; $display("FAIL oneshot_drain: %0d ticks outstanding, expected 0", q1.size()); end
  endtask

  task automatic test_restart_wrap;
    int c;
    c = cyc;
    bus.en[0] = 1'b1;
    q0.push_back(c + 11);
    q0.push_back(c + 16);
    wait_cyc(c + 5);
    bus.restart[0] = 1'b1;
    step(1);
    bus.restart[0] = 1'b0;
    n_cmp++;
    if (bus.tick[0] !== 1'b0) begin n_err++; $display("FAIL restart_wrap_tick: got %b expected 0", bus.tick[0]); end
    wait_cyc(c + 20);
    bus.en[0] = 1'b0;
    step(1);
    n_cmp++;
    if (bus.tick[0] !== 1'b0) begin n_err++; $display("FAIL endrop_tick: got %b expected 0", bus.tick[0]); end
    n_cmp++;
    if (bus.busy[0] !== 1'b0) begin n_err++; $display("FAIL endrop_busy: got %b expected 0", bus.busy[0]); end
    n_cmp++;
    if (q0.size() !== 0) begin n_err++; $display("FAIL restart_drain: %0d ticks outstanding, expected 0", q0.size()); end
  endtask

  task automatic test_period_zero;
    int c;
    c = cyc;
    bus.en[0] = 1'b1;
    q0.push_back(c + 6);
    q0.push_back(c + 11);
    wait_cyc(c + 7);
    bus.period_we    = 1'b1;
    bus.period_ch    = 1'b0;
    bus.period_wdata = 8'd0;
    step(1);
    bus.period_we = 1'b0;
    wait_cyc(c + 25);
    n_cmp++;
    if (bus.busy[0] !== 1'b1) begin n_err++; $display("FAIL parked_busy: got %b expected 1", bus.busy[0]); end
    bus.period_we    = 1'b1;
    bus.period_wdata = 8'd1;
    bus.restart[0]   = 1'b1;
    for (int i = 27; i <= 32; i++) q0.push_back(c + i);
    step(1);
    bus.period_we  = 1'b0;
    bus.restart[0] = 1'b0;
    wait_cyc(c + 32);
    bus.en[0]        = 1'b0;
    bus.period_we    = 1'b1;
    bus.period_wdata = 8'd5;
    step(1);
    bus.period_we = 1'b0;
    step(1);
    n_cmp++;
    if (q0.size() !== 0) begin n_err++; $display("FAIL zero_one_drain: %0d ticks outstanding, expected 0", q0.size()); end
  endtask

  task automatic test_reset_mid;
    int c;
    c = cyc;
    bus.en[0] = 1'b1;
    wait_cyc(c + 3);
    bus.period_we    = 1'b1;
    bus.period_ch    = 1'b0;
    bus.period_wdata = 8'd7;
    step(1);
    bus.period_we = 1'b0;
    reset         = 1'b1;
    step(1);
    n_cmp++;
    if (bus.busy !== 2'b00) begin n_err++; $display("FAIL midreset_busy: got %b expected 00", bus.busy); end
    n_cmp++;
    if (bus.tick !== 2'b00) begin n_err++; $display("FAIL midreset_tick: got %b expected 00", bus.tick); end
    n_cmp++;
    if (bus.done !== 2'b00) begin n_err++; $display("FAIL midreset_done: got %b expected 00", bus.done); end
    step(1);
    reset = 1'b0;
    q0.push_back(c + 12);
    q0.push_back(c + 17);
    step(1);
    n_cmp++;
    if (bus.busy[0] !== 1'b1) begin n_err++; $display("FAIL midreset_rerun: busy got %b expected 1", bus.busy[0]); end
    wait_cyc(c + 18);
    bus.en[0] = 1'b0;
    step(1);
    n_cmp++;
    if (q0.size() !== 0) begin n_err++; $display("FAIL midreset_drain: %0d ticks outstanding, expected 0", q0.size()); end
  endtask

  initial begin
    test_reset;
    test_periodic;
    test_period_update;
    test_oneshot;
    test_restart_wrap;
    test_period_zero;
    test_reset_mid;
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
